rdn_weight_fetch: RTL and testbench

RDN_WEIGHT_FETCH -- requirements
Module: rdn_weight_fetch

---
 rtl/rdn_weight_fetch.sv | 131 +++++++++++++
 tb/tb_rdn_weight_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdn_weight_fetch.sv
// Weight-block fetcher: issues eight contiguous word reads, collects the in-order
// responses into an 8-word buffer and hands the block over with a ready/request handshake.
module rdn_weight_fetch #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 req_mem,
    output logic                 mem_ready,
    output logic [63:0]          mem_data [7:0],
    output logic                 rd_req_valid,
    output logic [ADDR_W-1:0]    rd_req_addr,
    input  logic                 rd_req_ready,
    input  logic                 rd_rsp_valid,
    input  logic [63:0]          rd_rsp_data,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_cnt,
    output logic                 proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [3:0]           iss_cnt_q, iss_cnt_d;
    logic [3:0]           rsp_cnt_q, rsp_cnt_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic                 proto_err_q, proto_err_d;
    logic [63:0]          buf_q [7:0];
    logic                 rsp_wr;
    logic                 start;

    // A go is accepted in IDLE, and in READY unless a block request wins the cycle.
    assign start = go && ((state_q == IDLE) || ((state_q == READY) && !req_mem));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        iss_cnt_d   = iss_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        proto_err_d = proto_err_q;
        rsp_wr      = 1'b0;

        unique case (state_q)
            IDLE: ;
            ISSUE, DRAIN: begin
                if ((state_q == ISSUE) && rd_req_ready) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    iss_cnt_d = iss_cnt_q + 4'd1;
                end
                if (rd_rsp_valid && (rsp_cnt_q != 4'd8)) begin
                    rsp_wr    = 1'b1;
                    rsp_cnt_d = rsp_cnt_q + 4'd1;
                end
                // Block completion takes priority over the issue-done transition.
                if (rsp_cnt_d == 4'd8) begin
                    state_d   = READY;
                    blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                end else if (iss_cnt_d == 4'd8) begin
                    state_d = DRAIN;
                end
            end
            READY: begin
                if (req_mem) begin
                    state_d   = ISSUE;
                    iss_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d     = ISSUE;
            addr_d      = base_addr;
            iss_cnt_d   = '0;
            rsp_cnt_d   = '0;
            blk_cnt_d   = '0;
            proto_err_d = 1'b0;
        end

        if (req_mem && (state_q != READY)) begin
            proto_err_d = 1'b1;
        end
        if (rd_rsp_valid && !rsp_wr) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            iss_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            proto_err_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            iss_cnt_q   <= iss_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            proto_err_q <= proto_err_d;
            if (rsp_wr) begin
                buf_q[rsp_cnt_q[2:0]] <= rd_rsp_data;
            end
        end
    end

    assign mem_ready    = (state_q == READY);
    assign rd_req_valid = (state_q == ISSUE);
    assign rd_req_addr  = addr_q;
    assign busy         = (state_q != IDLE);
    assign blk_cnt      = blk_cnt_q;
    assign proto_err    = proto_err_q;
    assign mem_data     = buf_q;

endmodule

// File: tb/tb_rdn_weight_fetch.sv
// Bench for rdn_weight_fetch: a queue-based memory model answers reads in order and the
// expected blocks are derived from the address stream the loader should see.
module tb_rdn_weight_fetch;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst, go, req_mem, rd_req_ready, rd_rsp_valid;
    logic [AW-1:0] base_addr;
    logic [63:0]   rd_rsp_data;
    logic          mem_ready, rd_req_valid, busy, proto_err;
    logic [63:0]   mem_data [7:0];
    logic [AW-1:0] rd_req_addr;
    logic [15:0]   blk_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;
    int rsp_total = 0;
    int stall_cnt = 0;
    bit rand_ready = 0, rand_lat = 0, zero_lat = 0, inject = 0;
    logic [63:0]   inj_data;
    logic [AW-1:0] issued[$];
    logic [AW-1:0] pend[$];
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_blk;

    always #5 clk = ~clk;

    rdn_weight_fetch #(.ADDR_W(AW), .BLK_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .req_mem(req_mem),
        .mem_ready(mem_ready), .mem_data(mem_data), .rd_req_valid(rd_req_valid),
        .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_data(rd_rsp_data), .busy(busy), .blk_cnt(blk_cnt), .proto_err(proto_err)
    );

    // Memory contents: low half carries the address, high half a salted copy.
    function automatic logic [63:0] word_at(input logic [AW-1:0] a);
        return {a ^ 32'hC3A5_5A3C, a};
    endfunction

    task automatic mem_step();
        logic          acc;
        logic [AW-1:0] a;
        rd_rsp_valid = 1'b0;
        if (stall_cnt > 0) begin
            rd_req_ready = 1'b0;
            stall_cnt--;
        end else begin
            rd_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        acc = rd_req_valid && rd_req_ready;
        if (!zero_lat && pend.size() > 0 && (!rand_lat || $urandom_range(0, 2) != 0)) begin
            a = pend.pop_front();
            rd_rsp_valid = 1'b1; rd_rsp_data = word_at(a); last_rsp_cyc = cyc; rsp_total++;
        end
        if (acc) begin
            issued.push_back(rd_req_addr);
            pend.push_back(rd_req_addr);
        end
        if (zero_lat && !rd_rsp_valid && pend.size() > 0) begin
            a = pend.pop_front();
            rd_rsp_valid = 1'b1; rd_rsp_data = word_at(a); last_rsp_cyc = cyc; rsp_total++;
        end
        if (inject) begin
            rd_rsp_valid = 1'b1; rd_rsp_data = inj_data; inject = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_step();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (mem_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic start_go(input logic [AW-1:0] b);
        issued.delete();
        exp_addr  = b;
        exp_blk   = 16'd1;
        base_addr = b;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic next_blk();
        issued.delete();
        exp_addr = exp_addr + AW'(8);
        exp_blk++;
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid: got %b want 0", rd_req_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", proto_err); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL reset_blkcnt: got %0d want 0", blk_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== 64'd0) begin errors++; $display("FAIL reset_data[%0d]: got %h want 0", i, mem_data[i]); end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        start_go(32'h100);
        checks++; if (busy !== 1'b1 || rd_req_valid !== 1'b1) begin errors++; $display("FAIL basic_busy: got busy=%b valid=%b want 1/1", busy, rd_req_valid); end
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", mem_ready); end
        checks++; if (n < 9) begin errors++; $display("FAIL basic_min_cycles: got %0d want >=9", n); end
        checks++; if (cyc != last_rsp_cyc + 1) begin errors++; $display("FAIL basic_latency: got %0d want 1", cyc - last_rsp_cyc); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i))) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, mem_data[i], word_at(exp_addr + AW'(i))); end
            checks++;
            if (issued.size() != 8 || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %h (n=%0d) want %h", i, issued[i], issued.size(), exp_addr + AW'(i)); end
        end
        checks++; if (blk_cnt !== exp_blk) begin errors++; $display("FAIL basic_blkcnt: got %0d want %0d", blk_cnt, exp_blk); end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int b = 0; b < 3; b++) begin
            tick();
            next_blk();
            checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low[%0d]: got %b want 0", b, mem_ready); end
            wait_ready(n);
            checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", b, mem_ready); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mem_data[i] !== word_at(exp_addr + AW'(i))) begin errors++; $display("FAIL b2b_data[%0d][%0d]: got %h want %h", b, i, mem_data[i], word_at(exp_addr + AW'(i))); end
                checks++;
                if (issued.size() != 8 || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL b2b_addr[%0d][%0d]: got %h want %h", b, i, issued[i], exp_addr + AW'(i)); end
            end
        end
        checks++; if (blk_cnt !== 16'd4) begin errors++; $display("FAIL b2b_blkcnt: got %0d want 4", blk_cnt); end
    endtask

    task automatic test_stall();
        int n = 0;
        next_blk();
        while (issued.size() < 3 && n < 50) begin tick(); n++; end
        stall_cnt = 5;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rd_req_valid !== 1'b1 || rd_req_addr !== exp_addr + AW'(3)) begin errors++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h want 1/%h", k, rd_req_valid, rd_req_addr, exp_addr + AW'(3)); end
        end
        checks++; if (issued.size() != 3) begin errors++; $display("FAIL stall_accepts: got %0d want 3", issued.size()); end
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: got %b want 1", mem_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i))) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, mem_data[i], word_at(exp_addr + AW'(i))); end
            checks++;
            if (issued.size() != 8 || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i, issued[i], exp_addr + AW'(i)); end
        end
        checks++; if (blk_cnt !== exp_blk) begin errors++; $display("FAIL stall_blkcnt: got %0d want %0d", blk_cnt, exp_blk); end
    endtask

    task automatic test_proto();
        int n;
        next_blk();
        tick(); tick();
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_reqmem: got %b want 1", proto_err); end
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1 || proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got ready=%b perr=%b want 1/1", mem_ready, proto_err); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (issued.size() != 8 || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL proto_addr[%0d]: got %h want %h", i, issued[i], exp_addr + AW'(i)); end
        end
        inj_data = {$urandom, $urandom};
        inject = 1;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i))) begin errors++; $display("FAIL proto_stray_data[%0d]: got %h want %h", i, mem_data[i], word_at(exp_addr + AW'(i))); end
        end
        checks++; if (proto_err !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL proto_stray: got perr=%b ready=%b want 1/1", proto_err, mem_ready); end
        start_go(32'h300);
        checks++; if (proto_err !== 1'b0 || blk_cnt !== 16'd0) begin errors++; $display("FAIL proto_go_clear: got perr=%b blk=%0d want 0/0", proto_err, blk_cnt); end
        tick();
        base_addr = 32'h5000; go = 1'b1;
        tick();
        go = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_go_busy: got %b want 0", proto_err); end
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1 || blk_cnt !== 16'd1) begin errors++; $display("FAIL proto_restart: got ready=%b blk=%0d want 1/1", mem_ready, blk_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i)) || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL proto_restart_blk[%0d]: got %h @%h want %h", i, mem_data[i], issued[i], word_at(exp_addr + AW'(i))); end
        end
    endtask

    task automatic test_reset_midfetch();
        int n = 0;
        int r0;
        next_blk();
        r0 = rsp_total;
        while (rsp_total - r0 < 4 && n < 50) begin tick(); n++; end
        rst = 1'b1;
        pend.delete();
        tick();
        checks++; if (mem_ready !== 1'b0 || rd_req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got ready=%b valid=%b busy=%b want 0/0/0", mem_ready, rd_req_valid, busy); end
        checks++; if (proto_err !== 1'b0 || blk_cnt !== 16'd0 || rd_req_addr !== '0) begin errors++; $display("FAIL rstmid_cnt: got perr=%b blk=%0d addr=%h want 0/0/0", proto_err, blk_cnt, rd_req_addr); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== 64'd0) begin errors++; $display("FAIL rstmid_data[%0d]: got %h want 0", i, mem_data[i]); end
        end
        rst = 1'b0;
        inj_data = 64'hDEAD_0000_BEEF_0001;
        inject = 1;
        tick(); tick();
        checks++; if (proto_err !== 1'b1 || mem_data[0] !== 64'd0) begin errors++; $display("FAIL rstmid_late_rsp: got perr=%b d0=%h want 1/0", proto_err, mem_data[0]); end
        start_go(32'h200);
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1 || blk_cnt !== 16'd1 || proto_err !== 1'b0) begin errors++; $display("FAIL rstmid_refetch: got ready=%b blk=%0d perr=%b want 1/1/0", mem_ready, blk_cnt, proto_err); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i)) || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL rstmid_blk[%0d]: got %h @%h want %h", i, mem_data[i], issued[i], word_at(exp_addr + AW'(i))); end
        end
    endtask

    task automatic test_wrap();
        int n;
        zero_lat = 1;
        start_go(32'hFFFF_FFFC);
        wait_ready(n);
        checks++; if (mem_ready !== 1'b1 || blk_cnt !== 16'd1) begin errors++; $display("FAIL wrap_ready: got ready=%b blk=%0d want 1/1", mem_ready, blk_cnt); end
        checks++; if (issued.size() != 8 || issued[7] !== 32'h0000_0003) begin errors++; $display("FAIL wrap_last_addr: got %h want 00000003", issued[7]); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_data[i] !== word_at(exp_addr + AW'(i)) || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL wrap_blk[%0d]: got %h @%h want %h", i, mem_data[i], issued[i], word_at(exp_addr + AW'(i))); end
        end
        zero_lat = 0;
    endtask

    task automatic test_random();
        int n;
        rand_ready = 1;
        rand_lat   = 1;
        for (int b = 0; b < 10; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            zero_lat = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) start_go($urandom);
            else next_blk();
            checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rand_ready_low[%0d]: got %b want 0", b, mem_ready); end
            wait_ready(n);
            checks++; if (mem_ready !== 1'b1 || blk_cnt !== exp_blk) begin errors++; $display("FAIL rand_done[%0d]: got ready=%b blk=%0d want 1/%0d", b, mem_ready, blk_cnt, exp_blk); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mem_data[i] !== word_at(exp_addr + AW'(i)) || issued.size() != 8 || issued[i] !== exp_addr + AW'(i)) begin errors++; $display("FAIL rand_blk[%0d][%0d]: got %h @%h want %h @%h", b, i, mem_data[i], issued[i], word_at(exp_addr + AW'(i)), exp_addr + AW'(i)); end
            end
        end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_perr: got %b want 0", proto_err); end
        rand_ready = 0; rand_lat = 0; zero_lat = 0;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; req_mem = 1'b0; base_addr = '0;
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        exp_addr = '0; exp_blk = '0; inj_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_proto();
        test_reset_midfetch();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
